// File: rtl/rom_pkg.sv
// Shared definitions for the 32Kx8 parallel ROM and its clients.
// Holds ROM geometry and the read-master FSM state encoding.
package rom_pkg;

   localparam int ROM_ADDR_W = 15;
   localparam int ROM_DATA_W = 8;
   localparam int ROM_DEPTH  = 32768;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_PRESENT,
      ST_DONE
   } rom_state_e;

endpackage

// File: rtl/rom_stream_reader_if.sv
// ROM pin bus plus downstream byte stream of the ROM read master.
// master: drives rom_addr/rom_oen/m_data/m_valid, reads rom_data/m_ready.
interface rom_stream_reader_if
   import rom_pkg::*;
#(
   parameter int ADDR_W = ROM_ADDR_W,
   parameter int DATA_W = ROM_DATA_W
);

   logic [ADDR_W-1:0] rom_addr;
   logic              rom_oen;
   logic [DATA_W-1:0] rom_data;
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;

   modport master (
      output rom_addr, rom_oen, m_data, m_valid,
      input  rom_data, m_ready
   );

   modport slave (
      input  rom_addr, rom_oen, m_data, m_valid,
      output rom_data, m_ready
   );

endinterface

// File: rtl/rom_stream_reader.sv
// Reads length bytes from the parallel ROM starting at start_addr and
// streams them out. Ports: clk, rstn, start/start_addr/length, busy, done, bus.
module rom_stream_reader
   import rom_pkg::*;
#(
   parameter int ADDR_W      = ROM_ADDR_W,
   parameter int DATA_W      = ROM_DATA_W,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                start,
   input  logic [ADDR_W-1:0]   start_addr,
   input  logic [ADDR_W:0]     length,
   output logic                busy,
   output logic                done,
   rom_stream_reader_if.master bus
);

   localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [WW-1:0]   WLAST   = WW'(WAIT_CYCLES - 1);
   localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);

   rom_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic [WW-1:0]     wait_q, wait_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              oen_q, oen_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      wait_d  = wait_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      oen_d   = 1'b1;
      data_d  = data_q;
      valid_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (length != '0) begin
                  state_d = ST_ACCESS;
                  addr_d  = start_addr;
                  rem_d   = length;
                  wait_d  = '0;
                  busy_d  = 1'b1;
                  oen_d   = 1'b0;
               end else begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end
            end
         end
         ST_ACCESS: begin
            oen_d = 1'b0;
            // last wait cycle: capture bus and release the ROM
            if (wait_q == WLAST) begin
               data_d  = bus.rom_data;
               oen_d   = 1'b1;
               valid_d = 1'b1;
               state_d = ST_PRESENT;
            end else begin
               wait_d = wait_q + WW'(1);
            end
         end
         ST_PRESENT: begin
            valid_d = 1'b1;
            if (bus.m_ready) begin
               valid_d = 1'b0;
               // address wraps naturally at the ROM top
               addr_d  = addr_q + ADDR_W'(1);
               rem_d   = rem_q - REM_ONE;
               if (rem_q == REM_ONE) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d = ST_ACCESS;
                  oen_d   = 1'b0;
                  wait_d  = '0;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         wait_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         oen_q   <= 1'b1;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         wait_q  <= wait_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         oen_q   <= oen_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign bus.rom_addr = addr_q;
   assign bus.rom_oen  = oen_q;
   assign bus.m_data   = data_q;
   assign bus.m_valid  = valid_q;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Randomized bench for rom_stream_reader with a 1-cycle-latency ROM model
// and a queue-based expected byte stream.
module tb_rom_stream_reader;

   localparam int W = 2;

   logic        clk;
   logic        rstn;
   logic        start;
   logic [14:0] start_addr;
   logic [15:0] length;
   logic        busy;
   logic        done;

   rom_stream_reader_if #(.ADDR_W(15), .DATA_W(8)) bus ();

   rom_stream_reader #(
      .ADDR_W(15), .DATA_W(8), .WAIT_CYCLES(W)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start),
      .start_addr(start_addr), .length(length),
      .busy(busy), .done(done), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] mem [0:32767];

   always @(posedge clk)
      bus.rom_data <= bus.rom_oen ? 8'h00 : mem[bus.rom_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   int ea_q[$];
   int ed_q[$];
   int first_val = -1;
   bit oen_seen = 0;
   bit val_seen = 0;
   int done_cnt = 0;
   bit pv = 0, pr = 0;
   logic [7:0]  pd = '0;
   logic [14:0] pa = '0;

   always @(negedge clk) begin
      #4;
      if (rstn) begin
         if (bus.m_valid) begin
            val_seen = 1;
            if (first_val < 0) first_val = cyc;
            chk("oen_pres", bus.rom_oen, 1);
         end
         if (!bus.rom_oen) oen_seen = 1;
         if (pv && !pr) begin
            chk("hold_v", bus.m_valid, 1);
            chk("hold_d", bus.m_data, pd);
            chk("hold_a", bus.rom_addr, pa);
         end
         if (bus.m_valid && bus.m_ready) begin
            if (ea_q.size() == 0) begin
               chk("extra", 1, 0);
            end else begin
               chk("addr", bus.rom_addr, ea_q.pop_front());
               chk("data", bus.m_data, ed_q.pop_front());
            end
         end
         if (done) done_cnt++;
      end
      pv = bus.m_valid;
      pr = bus.m_ready;
      pd = bus.m_data;
      pa = bus.rom_addr;
   end

   task automatic load_exp(input logic [14:0] a, input int n);
      ea_q.delete();
      ed_q.delete();
      for (int i = 0; i < n; i++) begin
         int ad;
         ad = (int'(a) + i) % 32768;
         ea_q.push_back(ad);
         ed_q.push_back(int'(mem[ad]));
      end
   endtask

   // mode 0: ready high, 1: random ready, 2: 5-cycle stall, 3: stray start
   task automatic xfer(input logic [14:0] a, input int n, input int mode);
      int k;
      int stall;
      bit got;
      load_exp(a, n);
      @(negedge clk);
      start = 1'b1;
      start_addr = a;
      length = 16'(n);
      bus.m_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      k = cyc + 1;
      first_val = -1;
      oen_seen = 0;
      val_seen = 0;
      stall = 0;
      got = 0;
      @(negedge clk);
      start = 1'b0;
      start_addr = 15'($urandom);
      length = 16'($urandom);
      for (int t = 0; t < n * (W + 1) * 4 + 40 && !got; t++) begin
         if (t == 0) begin
            chk("busy_st", busy, (n != 0) ? 1 : 0);
            chk("oen_st", bus.rom_oen, (n != 0) ? 0 : 1);
         end
         if (done) begin
            got = 1;
            if (mode == 0 || mode == 3)
               chk("done_t", cyc, k + n * (W + 1));
            if (mode == 2)
               chk("done_ts", cyc, k + n * (W + 1) + 5);
            if (mode == 0 && n != 0)
               chk("first_v", first_val, k + W);
            chk("left", ea_q.size(), 0);
            chk("busy_dn", busy, 0);
            if (n == 0) begin
               chk("oen_z", oen_seen, 0);
               chk("val_z", val_seen, 0);
            end
         end else begin
            if (mode == 1) begin
               bus.m_ready = 1'($urandom_range(0, 1));
            end else if (mode == 2 && bus.m_valid && stall < 5) begin
               bus.m_ready = 1'b0;
               stall++;
            end else begin
               bus.m_ready = 1'b1;
            end
            if (mode == 3 && t == 3) begin
               start = 1'b1;
               start_addr = 15'h1234;
               length = 16'd7;
            end else begin
               start = 1'b0;
            end
            @(negedge clk);
         end
      end
      start = 1'b0;
      if (!got) begin
         chk("timeout", 0, 1);
      end else begin
         @(negedge clk);
         chk("done_1c", done, 0);
      end
   endtask

   task automatic abort_run();
      int dc;
      load_exp(15'h0100, 5);
      @(negedge clk);
      start = 1'b1;
      start_addr = 15'h0100;
      length = 16'd5;
      bus.m_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int t = 0; t < 60; t++) begin
         if (ea_q.size() == 4 && !bus.rom_oen) break;
         @(negedge clk);
      end
      chk("ab_at", ea_q.size(), 4);
      dc = done_cnt;
      rstn = 1'b0;
      @(negedge clk);
      chk("ab_oen", bus.rom_oen, 1);
      chk("ab_val", bus.m_valid, 0);
      chk("ab_busy", busy, 0);
      chk("ab_done", done, 0);
      rstn = 1'b1;
      ea_q.delete();
      ed_q.delete();
      repeat (3) @(negedge clk);
      chk("ab_ndone", done_cnt, dc);
   endtask

   initial begin
      rstn = 1'b0;
      start = 1'b0;
      start_addr = '0;
      length = '0;
      bus.m_ready = 1'b0;
      for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr", bus.rom_addr, 0);
      chk("rst_oen", bus.rom_oen, 1);
      chk("rst_data", bus.m_data, 0);
      chk("rst_val", bus.m_valid, 0);
      rstn = 1'b1;
      xfer(15'h0000, 3, 0);
      xfer(15'h7FFE, 4, 0);
      xfer(15'h0200, 3, 2);
      xfer(15'h0000, 0, 0);
      abort_run();
      xfer(15'h0010, 2, 0);
      xfer(15'h0400, 5, 3);
      for (int i = 0; i < 8; i++) begin
         logic [14:0] a;
         a = (i == 0) ? 15'h7FFD : 15'($urandom);
         xfer(a, int'($urandom_range(1, 6)), 1);
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
